mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage core.
- Data requests have priority. A starvation counter guarantees forward progress for fetch.
- One transaction is outstanding at a time. A fetch flush (branch redirect) discards an in-flight fetch response.

Parameters:
- ADDR_WIDTH, 32, address width; matches MEM_ADDRESS_WIDTH.
- DATA_WIDTH, 32, data width; matches REGISTER_WIDTH.
- STARVE_LIMIT, 4, consecutive data grants while fetch is pending before fetch is forced; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch read request.
- if_req_addr  in  ADDR_WIDTH  fetch address.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_flush  in  1  discard any outstanding fetch response.
- if_rsp_valid  out  1  fetch data valid; one-cycle pulse.
- if_rsp_data  out  DATA_WIDTH  fetched instruction.
- dm_req_valid  in  1  data request.
- dm_req_addr  in  ADDR_WIDTH  data address.
- dm_req_we  in  1  1 = store, 0 = load.
- dm_req_wstrb  in  DATA_WIDTH/8  byte enables for stores.
- dm_req_wdata  in  DATA_WIDTH  store data.
- dm_req_ready  out  1  data request accepted this cycle.
- dm_rsp_valid  out  1  load data or store acknowledge; one-cycle pulse.
- dm_rsp_data  out  DATA_WIDTH  load data; don't-care for stores.
- mem_req_valid  out  1  request to memory.
- mem_req_addr  out  ADDR_WIDTH  registered address.
- mem_req_we  out  1  registered write enable.
- mem_req_wstrb  out  DATA_WIDTH/8  registered byte strobes.
- mem_req_wdata  out  DATA_WIDTH  registered write data.
- mem_req_ready  in  1  memory accepts request.
- mem_rsp_valid  in  1  memory response; exactly one per accepted request, reads and writes alike.
- mem_rsp_data  in  DATA_WIDTH  read data.

Behaviour:

States:
- IDLE, ISSUE, WAIT_RSP.
- Reset (rst_n low, asynchronous) forces: state = IDLE; owner = DATA; drop = 0; starve_cnt = 0; all request registers = 0.
- After reset, every output is 0.

IDLE:
- If any request is valid, arbitrate and latch the winner's addr/we/wstrb/wdata. For fetch, latch we = 0 and wstrb = 0.
- Pulse the winner's *_req_ready for that single cycle. This is the acceptance cycle.
- Set owner to the winner and go to ISSUE.
- The loser's ready stays 0.

Arbitration:
- Only one requester valid: that requester wins.
- Both valid: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.

starve_cnt:
- Increments, saturating at STARVE_LIMIT, on each data grant while if_req_valid = 1.
- Clears on a fetch grant, or in any IDLE cycle with if_req_valid = 0.

ISSUE:
- mem_req_valid = 1 with the registered fields held stable.
- On mem_req_ready = 1, go to WAIT_RSP.

WAIT_RSP:
- mem_req_valid = 0.
- On mem_rsp_valid = 1, route the response combinationally to the owner: `owner_rsp_valid = 1`, `owner_rsp_data = mem_rsp_data`.
- Exception: if owner = FETCH and drop = 1, suppress if_rsp_valid.
- Then clear drop and go to IDLE.

Latency:
- Acceptance at cycle T; mem_req_valid at T+1.
- With zero-wait memory (ready at T+1, response at T+2), rsp_valid occurs at T+2.
- Next acceptance is possible at T+3.

Flush:
- if_flush = 1 while owner = FETCH in ISSUE or WAIT_RSP sets drop.
- The memory request is never retracted. The response is consumed silently.
- if_flush in IDLE has no effect, and a fetch grant in the same cycle is still accepted.
- if_flush never affects data transactions.
- Flush coinciding with mem_rsp_valid in WAIT_RSP: the response is dropped.

Other rules:
- mem_rsp_valid outside WAIT_RSP is ignored.
- Requesters hold valid and payload stable until ready. Withdrawal before ready is permitted; the arbiter samples only in IDLE.
- rsp_valid outputs are never asserted without a matching accepted request.

Test Plan:
- Fetch only: if_req_addr = 0x100, zero-wait memory returning 0x00500093 -> if_req_ready at T, mem_req_addr = 0x100 with mem_req_we = 0 at T+1, if_rsp_valid with data 0x00500093 at T+2.
- Simultaneous requests: fetch 0x104; data store 0x2000, wdata = 0xDEADBEEF, wstrb = 0xF -> data granted first; mem_req fields 0x2000/1/0xF/0xDEADBEEF; dm_rsp_valid pulse; fetch granted afterwards.
- Starvation: both requesters valid continuously with STARVE_LIMIT = 4 -> grant sequence D, D, D, D, F, D, D, D, D, F; starve_cnt is 0 after each F grant.
- Flush: fetch 0x200 granted; mem_req_ready delayed 3 cycles; if_flush pulsed in ISSUE -> request still issued, if_rsp_valid never asserted, state returns to IDLE after mem_rsp_valid, and the next fetch to 0x300 completes normally.
- Backpressure/stray response: mem_req_ready held low 5 cycles -> mem_req_* stable throughout, no *_req_ready pulses; a mem_rsp_valid injected during ISSUE produces no rsp_valid.
- Reset mid-transaction: rst_n low during WAIT_RSP of a data load -> all outputs 0 immediately (asynchronously); after release, the first dm request 0x40 is accepted in IDLE with starve_cnt = 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and data access.
// Data wins ties; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    if_req_valid,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr,
    output logic                    if_req_ready,
    input  logic                    if_flush,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_data,

    input  logic                    dm_req_valid,
    input  logic [ADDR_WIDTH-1:0]   dm_req_addr,
    input  logic                    dm_req_we,
    input  logic [DATA_WIDTH/8-1:0] dm_req_wstrb,
    input  logic [DATA_WIDTH-1:0]   dm_req_wdata,
    output logic                    dm_req_ready,
    output logic                    dm_rsp_valid,
    output logic [DATA_WIDTH-1:0]   dm_rsp_data,

    output logic                    mem_req_valid,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic                    mem_req_we,
    output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    input  logic                    mem_req_ready,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } state_e;

    typedef enum logic {
        OWN_DATA,
        OWN_FETCH
    } owner_e;

    state_e                 state_q,     state_d;
    owner_e                 owner_q,     owner_d;
    logic                   drop_q,      drop_d;
    logic [CNT_WIDTH-1:0]   starve_cnt_q, starve_cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q,      addr_d;
    logic                   we_q,        we_d;
    logic [STRB_WIDTH-1:0]  wstrb_q,     wstrb_d;
    logic [DATA_WIDTH-1:0]  wdata_q,     wdata_d;

    logic grant_if;
    logic grant_dm;
    logic rsp_fire;
    logic drop_now;

    always_comb begin
        grant_if = (state_q == IDLE) && if_req_valid &&
                   (!dm_req_valid || (starve_cnt_q == CNT_MAX));
        grant_dm = (state_q == IDLE) && dm_req_valid && !grant_if;
        rsp_fire = (state_q == WAIT_RSP) && mem_rsp_valid;
        // A flush arriving together with the response still kills it.
        drop_now = drop_q || if_flush;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        drop_d       = drop_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_if) begin
                    owner_d      = OWN_FETCH;
                    addr_d       = if_req_addr;
                    we_d         = 1'b0;
                    wstrb_d      = '0;
                    wdata_d      = '0;
                    starve_cnt_d = '0;
                    state_d      = ISSUE;
                end else if (grant_dm) begin
                    owner_d = OWN_DATA;
                    addr_d  = dm_req_addr;
                    we_d    = dm_req_we;
                    wstrb_d = dm_req_wstrb;
                    wdata_d = dm_req_wdata;
                    state_d = ISSUE;
                end

                if (!grant_if) begin
                    if (!if_req_valid) begin
                        starve_cnt_d = '0;
                    end else if (grant_dm && (starve_cnt_q != CNT_MAX)) begin
                        starve_cnt_d = starve_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end

            ISSUE: begin
                if ((owner_q == OWN_FETCH) && if_flush) begin
                    drop_d = 1'b1;
                end
                if (mem_req_ready) begin
                    state_d = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end else if ((owner_q == OWN_FETCH) && if_flush) begin
                    drop_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_DATA;
            drop_q       <= 1'b0;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            drop_q       <= drop_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
        end
    end

    // Ready and response paths are combinational; gating with rst_n keeps them low during reset.
    always_comb begin
        if_req_ready  = rst_n && grant_if;
        dm_req_ready  = rst_n && grant_dm;
        if_rsp_valid  = rst_n && rsp_fire && (owner_q == OWN_FETCH) && !drop_now;
        dm_rsp_valid  = rst_n && rsp_fire && (owner_q == OWN_DATA);
        if_rsp_data   = if_rsp_valid ? mem_rsp_data : '0;
        dm_rsp_data   = dm_rsp_valid ? mem_rsp_data : '0;

        mem_req_valid = (state_q == ISSUE);
        mem_req_addr  = addr_q;
        mem_req_we    = we_q;
        mem_req_wstrb = wstrb_q;
        mem_req_wdata = wdata_q;
    end

endmodule
